dsm_pwm_out: RTL

DSM_PWM_OUT -- requirements
Module: dsm_pwm_out

---
 rtl/dsm_pwm_out.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dsm_pwm_out.sv
// dsm_pwm_out: 16-clock PWM output stage for a delta-sigma quantizer.
// Quantizer codes arrive on fs_enb strobes, are held until the next frame
// boundary, and are converted to an offset-binary duty level. A small
// RUN/RAMP/MUTED state machine walks the level to mid-scale (8) when muted.
module dsm_pwm_out #(
    parameter int unsigned MUTE_INIT = 1,
    parameter int unsigned RAMP_DIV  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fs_enb,
    input  logic [3:0] outsig,
    input  logic       mute,
    input  logic       clr_flags,
    output logic       pwm_out,
    output logic       pwm_n,
    output logic       frame_start,
    output logic [3:0] level,
    output logic       muted,
    output logic       ovr_flag
);

    typedef enum logic [1:0] {
        StRun,
        StRamp,
        StMuted
    } state_e;

    localparam state_e     StInit  = (MUTE_INIT != 0) ? StMuted : StRun;
    localparam logic [7:0] DivLast = 8'(RAMP_DIV - 1);
    localparam logic [3:0] MidLvl  = 4'd8;

    logic [3:0] cnt_q;
    logic [3:0] hold_q;
    logic       pend_q;
    logic [3:0] level_q;
    logic [7:0] div_q;
    state_e     state_q;
    logic       ovr_q;
    logic       pwm_q;
    logic       pwm_n_q;
    logic       frame_start_q;

    logic       boundary;
    logic       ovr_set;
    logic       duty_hi;
    logic [3:0] sample_level;
    logic [3:0] ramp_level;

    assign boundary     = (cnt_q == 4'd15);
    // A second strobe before the held sample was consumed; a strobe on the
    // boundary itself belongs to the next frame and is not an overrun.
    assign ovr_set      = fs_enb & pend_q & ~boundary;
    assign duty_hi      = (cnt_q < level_q);
    // Two's complement to offset binary: flip the sign bit.
    assign sample_level = hold_q ^ 4'b1000;
    assign ramp_level   = (level_q > MidLvl) ? (level_q - 4'd1) : (level_q + 4'd1);

    // Free-running frame counter, one frame every 16 clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // Sample capture: newest strobe wins, pend is consumed at every boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            pend_q <= 1'b0;
        end else if (fs_enb) begin
            hold_q <= outsig;
            pend_q <= 1'b1;
        end else if (boundary) begin
            pend_q <= 1'b0;
        end
    end

    // Sticky overrun flag; a simultaneous set beats the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else if (ovr_set) begin
            ovr_q <= 1'b1;
        end else if (clr_flags) begin
            ovr_q <= 1'b0;
        end
    end

    // Mute state machine and duty level, both updated only at frame boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            level_q <= MidLvl;
            div_q   <= '0;
        end else if (boundary) begin
            unique case (state_q)
                StRun: begin
                    if (mute) begin
                        // Freeze the level on the way into the ramp.
                        state_q <= StRamp;
                        div_q   <= '0;
                    end else if (pend_q) begin
                        level_q <= sample_level;
                    end
                end
                StRamp: begin
                    if (!mute) begin
                        state_q <= StRun;
                        div_q   <= '0;
                        if (pend_q) begin
                            level_q <= sample_level;
                        end
                    end else if (level_q == MidLvl) begin
                        state_q <= StMuted;
                        div_q   <= '0;
                    end else if (div_q == DivLast) begin
                        div_q   <= '0;
                        level_q <= ramp_level;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                StMuted: begin
                    level_q <= (!mute && pend_q) ? sample_level : MidLvl;
                    if (!mute) begin
                        state_q <= StRun;
                    end
                end
                default: begin
                    state_q <= StInit;
                    level_q <= MidLvl;
                    div_q   <= '0;
                end
            endcase
        end
    end

    // Registered PWM drive, one clock behind the counter compare
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q         <= 1'b0;
            pwm_n_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pwm_q         <= duty_hi;
            pwm_n_q       <= ~duty_hi;
            frame_start_q <= (cnt_q == 4'd0);
        end
    end

    assign pwm_out     = pwm_q;
    assign pwm_n       = pwm_n_q;
    assign frame_start = frame_start_q;
    assign level       = level_q;
    assign muted       = (state_q == StMuted);
    assign ovr_flag    = ovr_q;

endmodule
